// File: rtl/round_ctrl.sv
// Match sequencer for the LED guessing game: arms the guess FSM each round,
// gates its step enable, holds each result and keeps win/loss/round counts.
module round_ctrl #(
  parameter int ROUNDS     = 9,
  parameter int HOLD_TICKS = 4,
  parameter int WIN_STREAK = 3,
  parameter int TW         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       win,
  input  logic       lose,
  output logic       fsm_rst,
  output logic       play_en,
  output logic       speed_sel,
  output logic [3:0] wins,
  output logic [3:0] losses,
  output logic [3:0] round,
  output logic [2:0] state,
  output logic       game_over
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARM       = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_HOLD_WIN  = 3'd3;
  localparam logic [2:0] S_HOLD_LOSE = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [3:0]    ROUNDS_C = 4'(ROUNDS);
  localparam logic [3:0]    STREAK_C = 4'(WIN_STREAK);
  localparam logic [TW-1:0] HOLD_END = TW'(HOLD_TICKS - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    wins_q, wins_d;
  logic [3:0]    losses_q, losses_d;
  logic [3:0]    round_q, round_d;
  logic [3:0]    streak_q, streak_d;
  logic [TW-1:0] hold_q, hold_d;
  logic          speed_q, speed_d;
  logic          hold_done_s;

  // start cuts a hold short even without a tick
  assign hold_done_s = start | (tick & (hold_q == HOLD_END));

  always_comb begin
    state_d  = state_q;
    wins_d   = wins_q;
    losses_d = losses_q;
    round_d  = round_q;
    streak_d = streak_q;
    hold_d   = hold_q;
    speed_d  = speed_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          wins_d   = 4'd0;
          losses_d = 4'd0;
          streak_d = 4'd0;
          speed_d  = 1'b0;
          round_d  = 4'd1;
          state_d  = S_ARM;
        end else begin
          state_d = state_q;
        end
      end
      S_ARM: begin
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (win) begin
          wins_d  = (wins_q == 4'd15) ? 4'd15 : wins_q + 4'd1;
          hold_d  = '0;
          state_d = S_HOLD_WIN;
          if (streak_q + 4'd1 == STREAK_C) begin
            speed_d  = 1'b1;
            streak_d = 4'd0;
          end else begin
            streak_d = streak_q + 4'd1;
          end
        end else if (lose) begin
          losses_d = (losses_q == 4'd15) ? 4'd15 : losses_q + 4'd1;
          streak_d = 4'd0;
          speed_d  = 1'b0;
          hold_d   = '0;
          state_d  = S_HOLD_LOSE;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_HOLD_WIN, S_HOLD_LOSE: begin
        if (hold_done_s) begin
          if (round_q == ROUNDS_C) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_ARM;
          end
        end else if (tick) begin
          hold_d = hold_q + TW'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wins_q   <= 4'd0;
      losses_q <= 4'd0;
      round_q  <= 4'd0;
      streak_q <= 4'd0;
      hold_q   <= '0;
      speed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wins_q   <= wins_d;
      losses_q <= losses_d;
      round_q  <= round_d;
      streak_q <= streak_d;
      hold_q   <= hold_d;
      speed_q  <= speed_d;
    end
  end

  assign fsm_rst   = (state_q == S_ARM);
  assign play_en   = tick & (state_q == S_PLAY);
  assign game_over = (state_q == S_DONE);
  assign speed_sel = speed_q;
  assign wins      = wins_q;
  assign losses    = losses_q;
  assign round     = round_q;
  assign state     = state_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with default parameters (9 rounds, hold 4, streak 3).
module tb_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, start, win, lose;
  logic       fsm_rst, play_en, speed_sel, game_over;
  logic [3:0] wins, losses, round;
  logic [2:0] state;
  int         n_cmp = 0;
  int         n_err = 0;

  round_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .win(win), .lose(lose),
    .fsm_rst(fsm_rst), .play_en(play_en), .speed_sel(speed_sel),
    .wins(wins), .losses(losses), .round(round), .state(state),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One round from PLAY: present the result, then run the four-tick hold.
  task automatic play_round(input logic w, input logic l, input logic [2:0] es,
                            input logic [3:0] ew, input logic [3:0] el,
                            input logic esp, input logic [2:0] after_hold,
                            input logic [3:0] eround);
    win = w; lose = l;
    clk1();
    chk("res_state", 8'(state), 8'(es));
    chk("res_wins", 8'(wins), 8'(ew));
    chk("res_losses", 8'(losses), 8'(el));
    chk("res_speed", 8'(speed_sel), 8'(esp));
    win = 1'b0; lose = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; clk1();
      tick = 1'b0; clk1();
    end
    chk("hold_state", 8'(state), 8'(es));
    chk("hold_play_en", 8'(play_en), 8'd0);
    tick = 1'b1; clk1(); tick = 1'b0;
    chk("post_state", 8'(state), 8'(after_hold));
    chk("post_round", 8'(round), 8'(eround));
    if (after_hold == 3'd1) begin
      chk("post_fsm_rst", 8'(fsm_rst), 8'd1);
      clk1();
      chk("post_fsm_rst_off", 8'(fsm_rst), 8'd0);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; win = 1'b0; lose = 1'b0;
    clk1(); clk1();
    rst = 1'b0;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_wins", 8'(wins), 8'd0);
    chk("rst_round", 8'(round), 8'd0);
    chk("rst_fsm_rst", 8'(fsm_rst), 8'd0);
    chk("rst_game_over", 8'(game_over), 8'd0);

    for (int i = 0; i < 20; i++) begin
      tick = (i % 4 == 0);
      #1;
      chk("idle_play_en", 8'(play_en), 8'd0);
      clk1();
    end
    chk("idle_state", 8'(state), 8'd0);
    chk("idle_losses", 8'(losses), 8'd0);

    // start together with a tick: IDLE ignores the tick
    start = 1'b1; tick = 1'b1;
    clk1();
    start = 1'b0;
    chk("arm_state", 8'(state), 8'd1);
    chk("arm_fsm_rst", 8'(fsm_rst), 8'd1);
    chk("arm_round", 8'(round), 8'd1);
    chk("arm_play_en", 8'(play_en), 8'd0);
    clk1();
    chk("play_state", 8'(state), 8'd2);
    chk("play_fsm_rst", 8'(fsm_rst), 8'd0);
    chk("play_en_tick", 8'(play_en), 8'd1);
    tick = 1'b0; #1;
    chk("play_en_notick", 8'(play_en), 8'd0);

    play_round(1'b1, 1'b0, 3'd3, 4'd1, 4'd0, 1'b0, 3'd1, 4'd2);
    play_round(1'b0, 1'b1, 3'd4, 4'd1, 4'd1, 1'b0, 3'd1, 4'd3);
    play_round(1'b1, 1'b0, 3'd3, 4'd2, 4'd1, 1'b0, 3'd1, 4'd4);
    play_round(1'b1, 1'b0, 3'd3, 4'd3, 4'd1, 1'b0, 3'd1, 4'd5);
    play_round(1'b1, 1'b0, 3'd3, 4'd4, 4'd1, 1'b1, 3'd1, 4'd6);
    play_round(1'b0, 1'b1, 3'd4, 4'd4, 4'd2, 1'b0, 3'd1, 4'd7);

    // round 7: win and lose together count as a win; start cuts the hold
    win = 1'b1; lose = 1'b1;
    clk1();
    win = 1'b0; lose = 1'b0;
    chk("both_state", 8'(state), 8'd3);
    chk("both_wins", 8'(wins), 8'd5);
    chk("both_losses", 8'(losses), 8'd2);
    start = 1'b1;
    clk1();
    start = 1'b0;
    chk("cut_state", 8'(state), 8'd1);
    chk("cut_round", 8'(round), 8'd8);
    clk1();

    play_round(1'b0, 1'b1, 3'd4, 4'd5, 4'd3, 1'b0, 3'd1, 4'd9);
    play_round(1'b0, 1'b1, 3'd4, 4'd5, 4'd4, 1'b0, 3'd5, 4'd9);
    chk("done_game_over", 8'(game_over), 8'd1);
    tick = 1'b1; clk1(); tick = 1'b0;
    chk("done_frozen_state", 8'(state), 8'd5);
    chk("done_frozen_wins", 8'(wins), 8'd5);
    chk("done_frozen_losses", 8'(losses), 8'd4);

    start = 1'b1;
    clk1();
    start = 1'b0;
    chk("rematch_state", 8'(state), 8'd1);
    chk("rematch_wins", 8'(wins), 8'd0);
    chk("rematch_losses", 8'(losses), 8'd0);
    chk("rematch_round", 8'(round), 8'd1);
    chk("rematch_game_over", 8'(game_over), 8'd0);
    clk1();
    chk("rematch_play", 8'(state), 8'd2);

    // asynchronous reset in the middle of PLAY
    tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", 8'(state), 8'd0);
    chk("midrst_round", 8'(round), 8'd0);
    chk("midrst_play_en", 8'(play_en), 8'd0);
    chk("midrst_speed", 8'(speed_sel), 8'd0);
    chk("midrst_fsm_rst", 8'(fsm_rst), 8'd0);
    rst = 1'b0; tick = 1'b0;
    clk1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
